grf_scoreboard: RTL and testbench

- Parametrised general register file for the pipelined CPU, replacing the single-write-port GRF in the decode stage.
- Provides NUM_RD combinational read ports and two write ports: port 0 for the late/WB stage, port 1 for the early/MEM-side writer.
- Each write port has a same-cycle write-to-read bypass.
- Holds a per-register pending-write scoreboard: issue increments a register's counter, commit decrements it. The hazard unit uses the counters to stall without re-decoding downstream stages.

---
 rtl/grf_pkg.sv | 17 +
 rtl/grf_pend_ctr.sv | 41 ++++
 rtl/grf_scoreboard.sv | 120 ++++++++++++
 tb/tb_grf_scoreboard.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
// grf_pkg: shared constants for the general register file with pending-write
// scoreboard, plus the trace line format used for architectural writes.
//   DEF_DATA_W / DEF_ADDR_W / DEF_CNT_W : default parameter values
//   ZERO_REG                            : hardwired-zero register index
`ifndef GRF_PKG_SV
`define GRF_PKG_SV

`define GRF_TRACE_FMT "%d@%h: $%d <= %h"

package grf_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CNT_W  = 2;
  localparam int ZERO_REG   = 0;
endpackage

`endif

// File: rtl/grf_pend_ctr.sv
// grf_pend_ctr: one saturating pending-write counter.
//   clk, reset : clock, synchronous active-high reset
//   inc        : one more write in flight (caller guarantees !full)
//   dec        : number of writes retiring this cycle (0..2)
//   cnt        : registered count
//   nonzero    : cnt != 0
//   full       : cnt at maximum
//   underflow  : more retires than cnt + inc; counter clamps to 0
module grf_pend_ctr #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic [1:0]       dec,
  output logic [CNT_W-1:0] cnt,
  output logic             nonzero,
  output logic             full,
  output logic             underflow
);

  logic [CNT_W+1:0] sum;
  logic [CNT_W+1:0] dec_w;

  assign sum       = {2'b00, cnt} + {{(CNT_W+1){1'b0}}, inc};
  assign dec_w     = {{CNT_W{1'b0}}, dec};
  assign underflow = dec_w > sum;
  assign nonzero   = |cnt;
  assign full      = &cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (underflow) begin
      cnt <= '0;
    end else begin
      cnt <= CNT_W'(sum - dec_w);
    end
  end

endmodule

// File: rtl/grf_scoreboard.sv
// grf_scoreboard: register file with two write ports, same-cycle bypass and a
// per-register pending-write counter used by the hazard unit.
//   clk, reset          : clock, synchronous active-high reset
//   rd_addr / rd_data   : NUM_RD packed combinational read ports
//   rd_busy             : addressed register has writes in flight
//   w0_* / w1_*         : write ports (port 0 has priority), *_commit retires
//                         one pending issue on the write address
//   iss_en / iss_addr   : mark a destination register as having a write in flight
//   iss_full            : iss_addr counter saturated (never for register 0)
//   err                 : sticky; counter underflow or issue while full
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 3,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int TRACE  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     w0_en,
  input  logic [ADDR_W-1:0]        w0_addr,
  input  logic [DATA_W-1:0]        w0_data,
  input  logic [31:0]              w0_pc,
  input  logic                     w0_commit,
  input  logic                     w1_en,
  input  logic [ADDR_W-1:0]        w1_addr,
  input  logic [DATA_W-1:0]        w1_data,
  input  logic [31:0]              w1_pc,
  input  logic                     w1_commit,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_full,
  output logic                     err
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];

  logic [DEPTH-1:0]            busy_vec;
  logic [DEPTH-1:0]            full_vec;
  logic [DEPTH-1:0]            unf_vec;
  logic [DEPTH-1:0][CNT_W-1:0] cnt_unused;

  logic w0_live, w1_live, w0_cmt, w1_cmt, iss_req, iss_ok;

  // Port 1 loses a same-address collision for storage, but its commit still
  // counts, so storage enables and commit qualifiers are kept separate.
  assign w0_live = w0_en && (w0_addr != ZERO_A);
  assign w1_live = w1_en && (w1_addr != ZERO_A) && !(w0_live && (w0_addr == w1_addr));
  assign w0_cmt  = w0_en && w0_commit && (w0_addr != ZERO_A);
  assign w1_cmt  = w1_en && w1_commit && (w1_addr != ZERO_A);

  assign iss_full = full_vec[iss_addr];
  assign iss_req  = iss_en && (iss_addr != ZERO_A);
  assign iss_ok   = iss_req && !iss_full;

  assign busy_vec[0]   = 1'b0;
  assign full_vec[0]   = 1'b0;
  assign unf_vec[0]    = 1'b0;
  assign cnt_unused[0] = '0;

  for (genvar g = 1; g < DEPTH; g++) begin : g_ctr
    logic       inc;
    logic [1:0] dec;

    assign inc = iss_ok && (iss_addr == ADDR_W'(g));
    assign dec = {1'b0, w0_cmt && (w0_addr == ADDR_W'(g))}
               + {1'b0, w1_cmt && (w1_addr == ADDR_W'(g))};

    grf_pend_ctr #(.CNT_W(CNT_W)) u_ctr (
      .clk       (clk),
      .reset     (reset),
      .inc       (inc),
      .dec       (dec),
      .cnt       (cnt_unused[g]),
      .nonzero   (busy_vec[g]),
      .full      (full_vec[g]),
      .underflow (unf_vec[g])
    );
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = rd_addr[p*ADDR_W +: ADDR_W];
    assign rd_data[p*DATA_W +: DATA_W] =
        (a == ZERO_A)                  ? '0      :
        (w0_en && (w0_addr == a))      ? w0_data :
        (w1_en && (w1_addr == a))      ? w1_data :
                                         regs[a];
    assign rd_busy[p] = busy_vec[a];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      err <= 1'b0;
    end else begin
      if (w0_live) regs[w0_addr] <= w0_data;
      if (w1_live) regs[w1_addr] <= w1_data;
      if ((|unf_vec) || (iss_req && iss_full)) err <= 1'b1;
    end
  end

  if (TRACE != 0) begin : g_trace
    always_ff @(posedge clk) begin
      if (!reset) begin
        if (w0_live) $display(`GRF_TRACE_FMT, $time, w0_pc, w0_addr, w0_data);
        if (w1_live) $display(`GRF_TRACE_FMT, $time, w1_pc, w1_addr, w1_data);
      end
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// tb_grf_scoreboard: directed test-plan sequences followed by random traffic.
// The driver pushes expected combinational outputs into a queue each cycle and
// advances a register/counter reference model; a negedge monitor pops and
// compares against the DUT.
module tb_grf_scoreboard;

  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NR   = 3;
  localparam int CW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_busy;
  logic              w0_en, w0_commit, w1_en, w1_commit, iss_en;
  logic [AW-1:0]     w0_addr, w1_addr, iss_addr;
  logic [DW-1:0]     w0_data, w1_data;
  logic [31:0]       w0_pc, w1_pc;
  logic              iss_full, err;

  always #5 clk = ~clk;

  grf_scoreboard #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .CNT_W(CW), .TRACE(1)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .w0_en(w0_en), .w0_addr(w0_addr), .w0_data(w0_data), .w0_pc(w0_pc), .w0_commit(w0_commit),
    .w1_en(w1_en), .w1_addr(w1_addr), .w1_data(w1_data), .w1_pc(w1_pc), .w1_commit(w1_commit),
    .iss_en(iss_en), .iss_addr(iss_addr), .iss_full(iss_full), .err(err)
  );

  typedef struct {
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]    busy;
    logic             full;
    logic             err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [DW-1:0] m_reg [32];
  int            m_cnt [32];
  bit            m_err;
  bit            m_valid = 0;

  function automatic logic [DW-1:0] m_read(logic [AW-1:0] a);
    if (a == 5'd0) return '0;
    if (w0_en && w0_addr == a) return w0_data;
    if (w1_en && w1_addr == a) return w1_data;
    return m_reg[a];
  endfunction

  function automatic void check(string name, logic [NR*DW-1:0] act, logic [NR*DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("rd_data",  rd_data, mon_e.rd_data);
      check("rd_busy",  {{(NR*DW-NR){1'b0}}, rd_busy}, {{(NR*DW-NR){1'b0}}, mon_e.busy});
      check("iss_full", {{(NR*DW-1){1'b0}}, iss_full}, {{(NR*DW-1){1'b0}}, mon_e.full});
      check("err",      {{(NR*DW-1){1'b0}}, err}, {{(NR*DW-1){1'b0}}, mon_e.err});
    end
  end

  // Push expectations for the inputs currently driven, advance the model by
  // one clock edge, then move to just after the DUT's edge.
  task automatic step();
    exp_t e;
    logic [AW-1:0] a;
    int inc, dec;
    if (m_valid) begin
      for (int p = 0; p < NR; p++) begin
        a = rd_addr[p*AW +: AW];
        e.rd_data[p*DW +: DW] = m_read(a);
        e.busy[p] = (a != 5'd0) && (m_cnt[a] != 0);
      end
      e.full = (iss_addr != 5'd0) && (m_cnt[iss_addr] == CMAX);
      e.err  = m_err;
      exp_q.push_back(e);
    end
    if (reset) begin
      for (int r = 0; r < 32; r++) begin
        m_reg[r] = '0;
        m_cnt[r] = 0;
      end
      m_err   = 1'b0;
      m_valid = 1'b1;
    end else begin
      if (w1_en && w1_addr != 5'd0) m_reg[w1_addr] = w1_data;
      if (w0_en && w0_addr != 5'd0) m_reg[w0_addr] = w0_data;
      for (int r = 1; r < 32; r++) begin
        inc = (iss_en && iss_addr == r && m_cnt[r] < CMAX) ? 1 : 0;
        dec = ((w0_en && w0_commit && w0_addr == r) ? 1 : 0)
            + ((w1_en && w1_commit && w1_addr == r) ? 1 : 0);
        if (iss_en && iss_addr == r && m_cnt[r] == CMAX) m_err = 1'b1;
        if (dec > m_cnt[r] + inc) begin
          m_cnt[r] = 0;
          m_err    = 1'b1;
        end else begin
          m_cnt[r] = m_cnt[r] + inc - dec;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0;
    w0_en = 1'b0; w0_commit = 1'b0; w0_addr = '0; w0_data = '0; w0_pc = '0;
    w1_en = 1'b0; w1_commit = 1'b0; w1_addr = '0; w1_data = '0; w1_pc = '0;
    iss_en = 1'b0; iss_addr = '0;
  endtask

  task automatic set_rd(int a0, int a1, int a2);
    rd_addr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic wr0(int a, logic [DW-1:0] d, bit c);
    w0_en = 1'b1; w0_addr = AW'(a); w0_data = d; w0_commit = c; w0_pc = 32'h0040_0000 + 32'(a * 4);
  endtask

  task automatic wr1(int a, logic [DW-1:0] d, bit c);
    w1_en = 1'b1; w1_addr = AW'(a); w1_data = d; w1_commit = c; w1_pc = 32'h0040_1000 + 32'(a * 4);
  endtask

  task automatic issue(int a);
    iss_en = 1'b1; iss_addr = AW'(a);
  endtask

  initial begin
    idle();
    set_rd(0, 0, 0);
    reset = 1'b1;
    step();
    step();

    // stale state: data, pending counters and err all set
    idle(); set_rd(5, 3, 6); wr0(5, 32'hDEAD_BEEF, 1'b0); issue(3); step();
    idle(); set_rd(5, 3, 6); wr0(2, 32'h1, 1'b1); step();
    idle(); set_rd(5, 3, 2); step();
    // reset with a write/issue held: both ignored
    idle(); set_rd(5, 3, 6); reset = 1'b1; wr0(6, 32'h0BAD_0BAD, 1'b0); issue(4); step();
    idle(); set_rd(5, 3, 6); iss_addr = 5'd4; step();

    // w0 bypass then stored read
    idle(); set_rd(5, 0, 5); wr0(5, 32'h1234_ABCD, 1'b0); step();
    idle(); set_rd(5, 0, 1); step();

    // same-address collision: port 0 wins; w1 to $0 is ignored
    idle(); set_rd(8, 8, 0); wr0(8, 32'hAAAA_0000, 1'b0); wr1(8, 32'h5555_FFFF, 1'b0); step();
    idle(); set_rd(8, 0, 5); step();
    idle(); set_rd(0, 8, 0); wr1(0, 32'hFFFF_FFFF, 1'b0); step();
    idle(); set_rd(0, 8, 5); step();

    // fill $3, overflow issue, then drain
    for (int k = 0; k < 3; k++) begin
      idle(); set_rd(3, 0, 0); issue(3); step();
    end
    idle(); set_rd(3, 0, 0); iss_addr = 5'd3; step();
    idle(); set_rd(3, 0, 0); issue(3); step();
    for (int k = 0; k < 3; k++) begin
      idle(); set_rd(3, 3, 0); iss_addr = 5'd3; wr0(3, 32'h3000 + 32'(k), 1'b1); step();
    end
    idle(); set_rd(3, 0, 0); iss_addr = 5'd3; step();

    // same-cycle issue and commit at zero is legal; a lone commit is not
    idle(); reset = 1'b1; step();
    idle(); set_rd(7, 0, 0); issue(7); wr0(7, 32'h7777_0001, 1'b1); step();
    idle(); set_rd(7, 0, 0); iss_addr = 5'd7; step();
    idle(); set_rd(7, 0, 0); wr1(7, 32'h7777_0002, 1'b1); step();
    idle(); set_rd(7, 0, 0); iss_addr = 5'd7; step();

    // double commit against a count of one
    idle(); reset = 1'b1; step();
    idle(); set_rd(9, 0, 0); issue(9); step();
    idle(); set_rd(9, 0, 0); wr0(9, 32'h9999_0000, 1'b1); wr1(9, 32'h9999_1111, 1'b1); step();
    idle(); set_rd(9, 0, 0); iss_addr = 5'd9; step();

    // random traffic over a narrow address range to force collisions
    idle(); reset = 1'b1; step();
    for (int n = 0; n < 1500; n++) begin
      idle();
      reset = ($urandom_range(0, 199) == 0);
      set_rd($urandom_range(0, 9), $urandom_range(0, 9), $urandom_range(0, 9));
      if ($urandom_range(0, 1) == 1) wr0($urandom_range(0, 9), $urandom, $urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1) wr1($urandom_range(0, 9), $urandom, $urandom_range(0, 3) == 0);
      iss_addr = AW'($urandom_range(0, 9));
      iss_en   = ($urandom_range(0, 1) == 1);
      step();
    end

    idle();
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
